fpmul_seq_ctrl: RTL and testbench
=================================

Name: fpmul_seq_ctrl

Overview:
- Multi-cycle sequencer for single-precision FP multiplication.
- Accepts operand pairs over a valid/ready handshake and unpacks the fields.
- Drives a 24-iteration shift-add mantissa multiplier, then one normalize step (leading-one detect, mantissa align, exponent adjust), then packs and holds the result until the consumer takes it.
- Sits between the FPU issue logic and the result writeback; one operation in flight at a time.

Parameters:
- EWIDTH, 8, exponent field width.
- MWIDTH, 23, stored mantissa width (significand = MWIDTH+1 bits, product M = 2*(MWIDTH+1) = 48).
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op_a  in  32  IEEE-754 single operand A.
- op_b  in  32  IEEE-754 single operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- result  out  32  packed product.
- overflow  out  1  result saturated to infinity; valid with out_valid.
- underflow  out  1  result flushed to zero; valid with out_valid.
- busy  out  1  high in any state except IDLE.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE; iteration counter is 0.
  - in_ready=1, out_valid=0, result=0, overflow=0, underflow=0, busy=0.
- States: IDLE, MULT, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch sign = a[31]^b[31].
  - Latch sum_exp = a_exp + b_exp − BIAS as a 10-bit signed value.
  - Latch significands {1,a_man} and {1,b_man}.
  - Clear the 48-bit accumulator and go to MULT.
- Zero fast path: if either operand has exp==0 (zero or denormal, both treated as zero), skip MULT/NORM.
  - Go directly to DONE with result={sign,31'b0}, flags 0.
  - out_valid is high the cycle after accept.
- MULT:
  - 24 cycles, counter 0..23.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left 1 and the multiplier right 1.
  - Counter==23 → NORM.
- NORM (1 cycle):
  - Leading one is at bit 47 or 46. position = 0 if p[47]=1, else 1.
  - Mantissa = (p << (position+1))[47:25]; truncation, no rounding.
  - e = sum_exp + 1 − position.
  - e ≥ 255 → result {sign,8'hFF,23'b0}, overflow=1.
  - e ≤ 0 → result {sign,31'b0}, underflow=1.
  - Otherwise result {sign,e[7:0],mantissa}.
  - Go to DONE.
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready → IDLE, out_valid=0 next cycle.
  - No new accept while in DONE; in_ready is low.
- Latency (accept at cycle 0):
  - Normal path: out_valid from cycle 26, i.e. 24 MULT + 1 NORM + 1.
  - Zero path: out_valid from cycle 1.
  - Throughput: one op per ≥27 cycles.
- Special inputs: exp==255 operands are processed as ordinary large numbers. No NaN/Inf propagation; these always overflow or produce a finite value, never a NaN.
- Reset mid-operation: any state returns to IDLE next cycle, the in-flight op is discarded and out_valid never rises for it.
- in_valid while busy: ignored, since in_ready=0; the upstream must hold it.
- out_ready while not out_valid: ignored.
- Inputs are sampled only on the accept cycle; later changes on op_a/op_b have no effect.

Decomposition:
- Shared package fp_pkg holds:
  - EWIDTH, MWIDTH, BIAS and EXP_MAX=255.
  - The state enum {IDLE,MULT,NORM,DONE}.
  - Field-slice helpers (sign/exp/man extraction, pack).
- Sub-module fpmul_shift_add_core holds the 48-bit accumulator, shift registers and 5-bit iteration counter.
  - Inputs: start, two 24-bit significands.
  - Outputs: 48-bit product and a done pulse.
- The FSM, exponent arithmetic and normalize/pack stay in fpmul_seq_ctrl.

Test Plan:
- 0x3FC00000 × 0x40000000 (1.5×2.0), out_ready=1 → result 0x40400000, flags 0, out_valid exactly cycle 26 after accept.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5, product leading one at bit 47) → 0x40100000; 0xBF800000 × 0x40490FDB → 0xC0490FDB.
- 0x00000000 × 0xC0490FDB → 0x80000000, out_valid at cycle 1, MULT never entered (busy high 1 cycle only).
- 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1; 0x00800000 × 0x00800000 → 0x00000000, underflow=1.
- out_ready held low 10 cycles in DONE → result/out_valid stable, in_ready=0, second in_valid not accepted; after out_ready pulse, next op accepted in IDLE.
- rst asserted at MULT cycle 10 → all outputs at reset values next cycle; a fresh 1.5×2.0 then yields 0x40400000 with normal latency.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, FSM state type and IEEE-754 single-precision field helpers
// for the sequential FP multiplier.
package fp_pkg;

    localparam int unsigned EWIDTH  = 8;
    localparam int unsigned MWIDTH  = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam int unsigned FP_W   = 1 + EWIDTH + MWIDTH;
    localparam int unsigned SIG_W  = MWIDTH + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned CNT_W  = 5;
    // Signed exponent width: room for 2*EXP_MAX - BIAS + 1 plus a sign bit.
    localparam int unsigned EXT_W  = EWIDTH + 2;

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_e;

    function automatic logic fp_sign(input logic [FP_W-1:0] x);
        return x[FP_W-1];
    endfunction

    function automatic logic [EWIDTH-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-2 -: EWIDTH];
    endfunction

    function automatic logic [MWIDTH-1:0] fp_man(input logic [FP_W-1:0] x);
        return x[MWIDTH-1:0];
    endfunction

    function automatic logic [FP_W-1:0] fp_pack(input logic              s,
                                                input logic [EWIDTH-1:0] e,
                                                input logic [MWIDTH-1:0] m);
        return {s, e, m};
    endfunction

endpackage

// File: rtl/fpmul_shift_add_core.sv
// Radix-2 shift-add significand multiplier: one partial product per cycle,
// SIG_W iterations after a start pulse, done pulses on the last iteration.
module fpmul_shift_add_core
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIG_W-1:0]  a_sig,
    input  logic [SIG_W-1:0]  b_sig,
    output logic [PROD_W-1:0] product,
    output logic              done
);

    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [SIG_W-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SIG_W - 1);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{(PROD_W-SIG_W){1'b0}}, a_sig};
            mplier_d = b_sig;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CntLast) begin
                cnt_d = '0;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign product = acc_q;
    assign done    = run_q && (cnt_q == CntLast);

endmodule

// File: rtl/fpmul_seq_ctrl.sv
// Sequencer for single-precision multiply: accept/unpack, shift-add mantissa
// product, one-cycle normalize with saturate/flush, then hold result until taken.
module fpmul_seq_ctrl
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] op_a,
    input  logic [FP_W-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            busy
);

    localparam logic signed [EXT_W-1:0] ExpMaxS = EXT_W'(EXP_MAX);
    localparam logic signed [EXT_W-1:0] BiasS   = EXT_W'(BIAS);
    localparam logic signed [EXT_W-1:0] OneS    = EXT_W'(1);

    state_e                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic signed [EXT_W-1:0]  sum_exp_q, sum_exp_d;
    logic [FP_W-1:0]          result_q, result_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;

    logic                     accept;
    logic                     zero_in;
    logic                     core_start;
    logic                     core_done;
    logic [PROD_W-1:0]        product;
    logic                     norm_pos;
    logic [MWIDTH-1:0]        mant_norm;
    logic signed [EXT_W-1:0]  e_norm;
    logic                     unused_prod_lsbs;

    assign accept  = in_valid && (state_q == IDLE);
    // Denormals have no hidden one here; they collapse onto the zero path.
    assign zero_in = (fp_exp(op_a) == '0) || (fp_exp(op_b) == '0);

    assign core_start = accept && !zero_in;

    fpmul_shift_add_core u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (core_start),
        .a_sig   ({1'b1, fp_man(op_a)}),
        .b_sig   ({1'b1, fp_man(op_b)}),
        .product (product),
        .done    (core_done)
    );

    // Product of two [1,2) significands lies in [1,4): leading one at 47 or 46.
    always_comb begin
        norm_pos  = ~product[PROD_W-1];
        mant_norm = norm_pos ? product[PROD_W-3 -: MWIDTH] : product[PROD_W-2 -: MWIDTH];
        e_norm    = sum_exp_q + OneS - (norm_pos ? OneS : '0);
    end

    assign unused_prod_lsbs = ^product[PROD_W-MWIDTH-3:0];

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        sum_exp_d = sum_exp_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d    = fp_sign(op_a) ^ fp_sign(op_b);
                    sum_exp_d = $signed({2'b00, fp_exp(op_a)}) + $signed({2'b00, fp_exp(op_b)})
                                - BiasS;
                    if (zero_in) begin
                        result_d = {fp_sign(op_a) ^ fp_sign(op_b), {(FP_W-1){1'b0}}};
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        state_d  = DONE;
                    end else begin
                        state_d = MULT;
                    end
                end
            end
            MULT: begin
                if (core_done) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                if (e_norm >= ExpMaxS) begin
                    result_d = fp_pack(sign_q, EWIDTH'(EXP_MAX), '0);
                    ovf_d    = 1'b1;
                end else if (e_norm < OneS) begin
                    result_d = {sign_q, {(FP_W-1){1'b0}}};
                    unf_d    = 1'b1;
                end else begin
                    result_d = fp_pack(sign_q, e_norm[EWIDTH-1:0], mant_norm);
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            sum_exp_q <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            sum_exp_q <= sum_exp_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fpmul_seq_ctrl.sv
// Self-checking bench for fpmul_seq_ctrl: directed corner cases plus random
// operand pairs against an arithmetic reference model.
module tb_fpmul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpmul_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product of the significands, then truncate.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov,
                                  output logic un, output logic zp);
        longint unsigned p;
        int              ea, eb, e;
        logic            s;
        logic [22:0]     m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ov = 1'b0;
        un = 1'b0;
        zp = 1'b0;
        if (ea == 0 || eb == 0) begin
            zp = 1'b1;
            r  = {s, 31'b0};
            return;
        end
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        if (p >= (64'd1 << 47)) begin
            e = ea + eb - 127 + 1;
            m = 23'(p >> 24);
        end else begin
            e = ea + eb - 127;
            m = 23'(p >> 23);
        end
        if (e >= 255) begin
            ov = 1'b1;
            r  = {s, 8'hFF, 23'b0};
        end else if (e <= 0) begin
            un = 1'b1;
            r  = {s, 31'b0};
        end else begin
            r = {s, 8'(e), m};
        end
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eo, eu, ez;
        int          lat;
        model(a, b, er, eo, eu, ez);
        @(negedge clk);
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        lat      = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), ez ? 32'd1 : 32'd26);
        check("result", result, er);
        check("overflow", 32'(overflow), 32'(eo));
        check("underflow", 32'(underflow), 32'(eu));
        check("busy_done", 32'(busy), 32'd1);
        if (hold > 0) begin
            in_valid = 1'b1;
            op_a     = 32'h3F800000;
            op_b     = 32'h3F800000;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", result, er);
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("released_valid", 32'(out_valid), 32'd0);
        check("released_busy", 32'(busy), 32'd0);
        check("released_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'b0, overflow, underflow}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(32'h3FC00000, 32'h40000000, 0);
        do_op(32'h3FC00000, 32'h3FC00000, 0);
        do_op(32'hBF800000, 32'h40490FDB, 0);
        do_op(32'h00000000, 32'hC0490FDB, 0);
        do_op(32'h7F000000, 32'h7F000000, 0);
        do_op(32'h00800000, 32'h00800000, 0);
        do_op(32'h7F800000, 32'h3F800000, 0);
        do_op(32'h40490FDB, 32'hC0000000, 10);
        do_op(32'h3FC00000, 32'h40000000, 0);

        // Abort an operation in the middle of MULT.
        @(negedge clk);
        op_a     = 32'h3FC00000;
        op_b     = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", {30'b0, overflow, underflow}, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        do_op(32'h3FC00000, 32'h40000000, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (i % 2 == 0) begin
                a[30:23] = 8'($urandom_range(160, 96));
                b[30:23] = 8'($urandom_range(160, 96));
            end
            if (i % 9 == 4) b[30:23] = 8'h00;
            do_op(a, b, (i % 7 == 3) ? 3 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
